array_dp_regclr: RTL and testbench

- Parametrised successor to the registered dual-clock RAM wrapper.
- Registers write and read commands, then stores data in an internal behavioural dual-clock array.
- Adds over the previous generation: per-byte write enables, a read-enable/valid pipeline, an optional output register, out-of-range protection, and a hardware memory-clear state machine.
- Sits under framers/mappers as the generic channel-state and buffer store.

---
 rtl/array_dp_regclr.sv | 251 +++++++++++++++++++++++++
 tb/tb_array_dp_regclr.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_dp_regclr.sv
// array_dp_regclr: registered dual-clock word store with per-byte write
// enables, out-of-range protection, read-valid pipeline, an optional output
// register and a wclk-side memory-clear sweep gated into the read domain.
// The read data port is named do_ because do is a reserved word.
module array_dp_regclr #(
    parameter int              ADDRBIT   = 5,
    parameter int              DEPTH     = 32,
    parameter int              WIDTH     = 32,
    parameter int              OREG      = 0,
    parameter int              MEM_RESET = 1,
    parameter logic [WIDTH-1:0] CLRVAL   = '0
) (
    input  logic                       rst_,
    input  logic                       wclk,
    input  logic                       rclk,
    input  logic                       clr,
    input  logic [ADDRBIT-1:0]         wa,
    input  logic                       we,
    input  logic [(WIDTH+7)/8-1:0]     wbe,
    input  logic [WIDTH-1:0]           di,
    output logic                       wr_drop,
    output logic                       init_done,
    input  logic [ADDRBIT-1:0]         ra,
    input  logic                       re,
    output logic [WIDTH-1:0]           do_,
    output logic                       rvalid
);

    localparam int NBYTE = (WIDTH + 7) / 8;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One bit wider than the address so DEPTH == 2**ADDRBIT is representable.
    localparam logic [ADDRBIT:0]   DEPTH_W   = (ADDRBIT+1)'(DEPTH);
    localparam logic [ADDRBIT-1:0] LAST_ADDR = ADDRBIT'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam state_e RST_STATE = (MEM_RESET != 0) ? ST_CLEAR : ST_IDLE;

    // Behavioural storage; never touched by rst_.
    logic [WIDTH-1:0] mem [0:DEPTH-1];

    // ------------------------------------------------------------------
    // Write domain
    // ------------------------------------------------------------------
    logic [ADDRBIT-1:0] iwa_q,   iwa_d;
    logic               iwe_q,   iwe_d;
    logic [NBYTE-1:0]   iwbe_q,  iwbe_d;
    logic [WIDTH-1:0]   idi_q,   idi_d;
    logic               iclr_q,  iclr_d;
    logic               wr_drop_q, wr_drop_d;
    state_e             state_q, state_d;
    logic [ADDRBIT-1:0] clr_addr_q, clr_addr_d;
    logic               init_done_q, init_done_d;

    logic               wr_hit;
    logic               wr_oor;
    logic               user_wr;
    logic               mem_we;
    logic [AW-1:0]      mem_wa;
    logic [WIDTH-1:0]   mem_wmask;
    logic [WIDTH-1:0]   mem_wd;

    // Command capture, drop decision and clear-sweep next state.
    // iclr remembers that a command was captured while a sweep was running,
    // which is what makes it a drop one edge later.
    always_comb begin
        iwa_d      = wa;
        iwe_d      = we;
        iwbe_d     = wbe;
        idi_d      = di;
        iclr_d     = (state_q == ST_CLEAR);

        wr_hit     = iwe_q && (iwbe_q != '0);
        wr_oor     = ({1'b0, iwa_q} >= DEPTH_W);
        wr_drop_d  = wr_hit && (iclr_q || wr_oor);
        user_wr    = wr_hit && !iclr_q && !wr_oor;

        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clr) begin
                    clr_addr_d = '0;
                end else if (clr_addr_q == LAST_ADDR) begin
                    state_d    = ST_IDLE;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            default: begin
                state_d    = RST_STATE;
                clr_addr_d = '0;
            end
        endcase
        init_done_d = (state_d == ST_IDLE);
    end

    // Array write port select: the sweep owns the port while it runs. A user
    // write captured in IDLE that lands on the first sweep edge is lost, but
    // the sweep overwrites every word anyway.
    always_comb begin
        mem_we    = 1'b0;
        mem_wa    = '0;
        mem_wmask = '0;
        mem_wd    = '0;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_wa    = clr_addr_q[AW-1:0];
            mem_wmask = '1;
            mem_wd    = CLRVAL;
        end else if (user_wr) begin
            mem_we    = 1'b1;
            mem_wa    = iwa_q[AW-1:0];
            mem_wd    = idi_q;
            for (int b = 0; b < WIDTH; b++) begin
                mem_wmask[b] = iwbe_q[b / 8];
            end
        end
    end

    // Write-domain registers, async active-low reset.
    always_ff @(posedge wclk or negedge rst_) begin
        if (!rst_) begin
            iwa_q       <= '0;
            iwe_q       <= 1'b0;
            iwbe_q      <= '0;
            idi_q       <= '0;
            iclr_q      <= 1'b0;
            wr_drop_q   <= 1'b0;
            state_q     <= RST_STATE;
            clr_addr_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            iwa_q       <= iwa_d;
            iwe_q       <= iwe_d;
            iwbe_q      <= iwbe_d;
            idi_q       <= idi_d;
            iclr_q      <= iclr_d;
            wr_drop_q   <= wr_drop_d;
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            init_done_q <= init_done_d;
        end
    end

    // Array write, bit-masked so unselected byte lanes keep their value.
    always_ff @(posedge wclk) begin
        if (mem_we) begin
            for (int b = 0; b < WIDTH; b++) begin
                if (mem_wmask[b]) begin
                    mem[mem_wa][b] <= mem_wd[b];
                end
            end
        end
    end

    assign wr_drop   = wr_drop_q;
    assign init_done = init_done_q;

    // ------------------------------------------------------------------
    // Read domain
    // ------------------------------------------------------------------
    logic [ADDRBIT-1:0] ra_q,    ra_d;
    logic               re_q,    re_d;
    logic               sync1_q, sync1_d;
    logic               rd_ok_q, rd_ok_d;
    logic [WIDTH-1:0]   rdat_q,  rdat_d;
    logic               rval_q,  rval_d;
    logic [WIDTH-1:0]   rd_word;
    logic               rd_oor;

    // Read command capture, init_done resync and the array read stage.
    // Until the sweep is seen finished in rclk, output is forced quiet.
    always_comb begin
        ra_d    = ra;
        re_d    = re;
        sync1_d = init_done_q;
        rd_ok_d = sync1_q;
        rd_word = mem[ra_q[AW-1:0]];
        rd_oor  = ({1'b0, ra_q} >= DEPTH_W);
        rdat_d  = rdat_q;
        rval_d  = 1'b0;
        if (!rd_ok_q) begin
            rdat_d = '0;
        end else if (re_q) begin
            rval_d = 1'b1;
            rdat_d = rd_oor ? '0 : rd_word;
        end
    end

    // Read-domain registers, async active-low reset.
    always_ff @(posedge rclk or negedge rst_) begin
        if (!rst_) begin
            ra_q    <= '0;
            re_q    <= 1'b0;
            sync1_q <= 1'b0;
            rd_ok_q <= 1'b0;
            rdat_q  <= '0;
            rval_q  <= 1'b0;
        end else begin
            ra_q    <= ra_d;
            re_q    <= re_d;
            sync1_q <= sync1_d;
            rd_ok_q <= rd_ok_d;
            rdat_q  <= rdat_d;
            rval_q  <= rval_d;
        end
    end

    generate
        if (OREG != 0) begin : g_oreg
            logic [WIDTH-1:0] odat_q, odat_d;
            logic             oval_q, oval_d;

            // Extra output stage, still gated by rd_ok.
            always_comb begin
                odat_d = rd_ok_q ? rdat_q : '0;
                oval_d = rd_ok_q && rval_q;
            end

            // Output register, async active-low reset.
            always_ff @(posedge rclk or negedge rst_) begin
                if (!rst_) begin
                    odat_q <= '0;
                    oval_q <= 1'b0;
                end else begin
                    odat_q <= odat_d;
                    oval_q <= oval_d;
                end
            end

            assign do_    = odat_q;
            assign rvalid = oval_q;
        end else begin : g_noreg
            assign do_    = rdat_q;
            assign rvalid = rval_q;
        end
    endgenerate

endmodule

// File: tb/tb_array_dp_regclr.sv
// Bench for array_dp_regclr: a plain instance and an OREG=1 instance share
// all inputs; a byte-lane memory model predicts read data.
`timescale 1ns/1ps
module tb_array_dp_regclr;

    localparam logic [31:0] CLRV = 32'hA5A5A5A5;

    logic        rst_;
    logic        wclk;
    logic        rclk;
    logic        clr;
    logic [5:0]  wa;
    logic        we;
    logic [3:0]  wbe;
    logic [31:0] di;
    logic        wr_drop;
    logic        init_done;
    logic [5:0]  ra;
    logic        re;
    logic [31:0] do_;
    logic        rvalid;
    logic        wr_drop2;
    logic        init_done2;
    logic [31:0] do2;
    logic        rvalid2;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [32];

    typedef struct {
        logic [5:0]  a;
        logic [3:0]  be;
        logic [31:0] d;
        logic        drop;
    } wvec_t;

    typedef struct {
        logic [5:0]  a;
        logic [31:0] exp;
    } rvec_t;

    wvec_t wtab [8];
    rvec_t rtab [8];

    logic mon_en  = 1'b0;
    int   low_run = 0;
    int   mon_n   = 0;

    array_dp_regclr #(.ADDRBIT(6), .DEPTH(32), .WIDTH(32), .OREG(0),
                      .MEM_RESET(1), .CLRVAL(CLRV)) u_dut (
        .rst_(rst_), .wclk(wclk), .rclk(rclk), .clr(clr),
        .wa(wa), .we(we), .wbe(wbe), .di(di),
        .wr_drop(wr_drop), .init_done(init_done),
        .ra(ra), .re(re), .do_(do_), .rvalid(rvalid)
    );

    array_dp_regclr #(.ADDRBIT(6), .DEPTH(32), .WIDTH(32), .OREG(1),
                      .MEM_RESET(1), .CLRVAL(CLRV)) u_dut_oreg (
        .rst_(rst_), .wclk(wclk), .rclk(rclk), .clr(clr),
        .wa(wa), .we(we), .wbe(wbe), .di(di),
        .wr_drop(wr_drop2), .init_done(init_done2),
        .ra(ra), .re(re), .do_(do2), .rvalid(rvalid2)
    );

    // Clocks: wclk ~19.44 MHz, rclk ~2.048 MHz.
    initial begin
        wclk = 1'b0;
        forever #25.72 wclk = ~wclk;
    end

    initial begin
        rclk = 1'b0;
        forever #244.14 rclk = ~rclk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                          input logic [31:0] d);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    // Count wclk edges until init_done is seen high.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge wclk);
            #1;
            n++;
        end while (init_done !== 1'b1 && n < 500);
        chk("init_done_timeout", 32'(init_done), 32'd1);
    endtask

    task automatic wr_chk(input logic [5:0] a, input logic [3:0] be, input logic [31:0] d,
                          input logic exp_drop, input string tag);
        @(negedge wclk);
        wa = a; we = 1'b1; wbe = be; di = d;
        @(posedge wclk);
        #1;
        chk({tag, "_drop_early"}, 32'(wr_drop), 32'd0);
        @(negedge wclk);
        we = 1'b0; wbe = 4'h0; di = $urandom;
        @(posedge wclk);
        #1;
        chk({tag, "_drop"}, 32'(wr_drop), 32'(exp_drop));
        if (!exp_drop && a < 6'd32) model[a[4:0]] = merge(model[a[4:0]], be, d);
    endtask

    task automatic rd_chk(input logic [5:0] a, input logic [31:0] exp, input string tag);
        @(negedge rclk);
        ra = a; re = 1'b1;
        @(negedge rclk);
        re = 1'b0; ra = 6'($urandom_range(0, 63));
        @(posedge rclk);
        #1;
        chk({tag, "_do"}, do_, exp);
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        chk({tag, "_rvalid2_early"}, 32'(rvalid2), 32'd0);
        @(posedge rclk);
        #1;
        chk({tag, "_rvalid_pulse"}, 32'(rvalid), 32'd0);
        chk({tag, "_do_hold"}, do_, exp);
        chk({tag, "_do2"}, do2, exp);
        chk({tag, "_rvalid2"}, 32'(rvalid2), 32'd1);
        @(posedge rclk);
        #1;
        chk({tag, "_rvalid2_pulse"}, 32'(rvalid2), 32'd0);
    endtask

    // Gating monitor: once init_done has been low for 3 rclk samples the
    // resynchronised gate must be holding the read outputs quiet.
    always @(negedge rclk) begin
        if (mon_en && init_done === 1'b0) low_run++;
        else low_run = 0;
    end

    always @(posedge rclk) begin
        if (mon_en && low_run >= 3) begin
            #1;
            mon_n++;
            chk("gate_rvalid", 32'(rvalid), 32'd0);
            chk("gate_do", do_, 32'd0);
            chk("gate_rvalid2", 32'(rvalid2), 32'd0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [5:0]  a;
        logic [3:0]  be;
        logic [31:0] d;
        logic        drop;

        wtab[0] = '{a: 6'd5,  be: 4'hF, d: 32'h11223344, drop: 1'b0};
        wtab[1] = '{a: 6'd5,  be: 4'h5, d: 32'hFFFFFFFF, drop: 1'b0};
        wtab[2] = '{a: 6'd40, be: 4'hF, d: 32'hDEADBEEF, drop: 1'b1};
        wtab[3] = '{a: 6'd7,  be: 4'h0, d: 32'h12345678, drop: 1'b0};
        wtab[4] = '{a: 6'd9,  be: 4'h8, d: 32'hAB000000, drop: 1'b0};
        wtab[5] = '{a: 6'd31, be: 4'h2, d: 32'h0000CD00, drop: 1'b0};
        wtab[6] = '{a: 6'd0,  be: 4'hF, d: 32'h01020304, drop: 1'b0};
        wtab[7] = '{a: 6'd32, be: 4'h1, d: 32'h000000EE, drop: 1'b1};

        rtab[0] = '{a: 6'd5,  exp: 32'h11FF33FF};
        rtab[1] = '{a: 6'd7,  exp: 32'hA5A5A5A5};
        rtab[2] = '{a: 6'd40, exp: 32'h00000000};
        rtab[3] = '{a: 6'd9,  exp: 32'hABA5A5A5};
        rtab[4] = '{a: 6'd31, exp: 32'hA5A5CDA5};
        rtab[5] = '{a: 6'd0,  exp: 32'h01020304};
        rtab[6] = '{a: 6'd32, exp: 32'h00000000};
        rtab[7] = '{a: 6'd63, exp: 32'h00000000};

        rst_ = 1'b0; clr = 1'b0; wa = '0; we = 1'b0; wbe = '0; di = '0;
        ra = '0; re = 1'b0;

        // Reset state
        #100;
        chk("rst_do", do_, 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_do2", do2, 32'd0);
        chk("rst_rvalid2", 32'(rvalid2), 32'd0);
        chk("rst_wr_drop", 32'(wr_drop), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);

        // Power-up sweep takes exactly DEPTH edges
        @(negedge wclk);
        rst_ = 1'b1;
        wait_done(n);
        chk("powerup_sweep_len", 32'(n), 32'd32);
        for (int i = 0; i < 32; i++) model[i] = CLRV;
        repeat (4) @(posedge rclk);

        for (int i = 0; i < 32; i++) rd_chk(6'(i), model[i], "clear_read");

        // Byte-lane writes and range protection
        foreach (wtab[i]) wr_chk(wtab[i].a, wtab[i].be, wtab[i].d, wtab[i].drop, "wtab");
        foreach (rtab[i]) rd_chk(rtab[i].a, rtab[i].exp, "rtab");

        // Write captured during a sweep is dropped
        @(negedge wclk); clr = 1'b1;
        @(negedge wclk); clr = 1'b0;
        repeat (5) @(negedge wclk);
        wr_chk(6'd3, 4'hF, 32'h77777777, 1'b1, "clear_wr");
        wait_done(n);
        for (int i = 0; i < 32; i++) model[i] = CLRV;
        repeat (4) @(posedge rclk);
        rd_chk(6'd3, CLRV, "after_drop3");
        rd_chk(6'd5, CLRV, "after_clear5");

        // Sweep restart at clr_addr=10, read outputs gated meanwhile
        wr_chk(6'd12, 4'hF, 32'h5A5A0001, 1'b0, "pre_restart");
        low_run = 0;
        mon_n   = 0;
        mon_en  = 1'b1;
        @(negedge rclk); ra = 6'd12; re = 1'b1;
        @(negedge wclk); clr = 1'b1;
        @(negedge wclk); clr = 1'b0;
        repeat (10) @(posedge wclk);
        @(negedge wclk); clr = 1'b1;
        @(negedge wclk); clr = 1'b0;
        wait_done(n);
        chk("restart_sweep_len", 32'(11 + n), 32'd43);
        mon_en = 1'b0;
        chk("gate_checked", 32'(mon_n > 0), 32'd1);
        @(negedge rclk); re = 1'b0;
        repeat (4) @(posedge rclk);
        for (int i = 0; i < 32; i++) model[i] = CLRV;
        rd_chk(6'd12, CLRV, "after_restart");

        // Reset asserted mid-sweep
        wr_chk(6'd20, 4'hF, 32'hC0FFEE00, 1'b0, "pre_rst");
        rd_chk(6'd20, 32'hC0FFEE00, "pre_rst");
        @(negedge wclk); clr = 1'b1;
        @(negedge wclk); clr = 1'b0;
        repeat (7) @(posedge wclk);
        #2;
        rst_ = 1'b0;
        #1;
        chk("midrst_do", do_, 32'd0);
        chk("midrst_rvalid", 32'(rvalid), 32'd0);
        chk("midrst_do2", do2, 32'd0);
        chk("midrst_init_done", 32'(init_done), 32'd0);
        repeat (3) @(negedge wclk);
        rst_ = 1'b1;
        wait_done(n);
        chk("midrst_sweep_len", 32'(n), 32'd32);
        for (int i = 0; i < 32; i++) model[i] = CLRV;
        repeat (4) @(posedge rclk);
        rd_chk(6'd20, CLRV, "after_midrst20");
        rd_chk(6'd31, CLRV, "after_midrst31");

        // Random traffic against the model
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                a    = 6'($urandom_range(0, 39));
                be   = 4'($urandom_range(0, 15));
                d    = $urandom;
                drop = (a >= 6'd32) && (be != 4'h0);
                wr_chk(a, be, d, drop, "rand_wr");
            end else begin
                a = 6'($urandom_range(0, 35));
                rd_chk(a, (a < 6'd32) ? model[a[4:0]] : 32'd0, "rand_rd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
